// File: rtl/mux_share_arbiter_if.sv
// Handshake/bus bundle between the two producers, the shared arbiter and the
// downstream consumer. The arbiter takes the master view (it owns grants, select
// and the captured data); producers/consumer take the slave view.
interface mux_share_arbiter_if #(
  parameter int DATA_W = 4
);
  logic              req_a;
  logic [DATA_W-1:0] data_a;
  logic              req_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              sel;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (
    input  req_a, data_a, req_b, data_b,
    output gnt_a, gnt_b, sel, data_out, valid_out
  );

  modport slave (
    output req_a, data_a, req_b, data_b,
    input  gnt_a, gnt_b, sel, data_out, valid_out
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter sharing one registered DATA_W-bit datapath.
// A granted requester transfers one nibble per cycle while it keeps req high;
// after HOLD_CYCLES back-to-back transfers the grant moves to the other side if
// it is waiting, otherwise the burst simply continues.
module mux_share_arbiter #(
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mux_share_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // Last transfer slot of a burst; counter wraps or hands over here.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic              last_served_q, last_served_d;  // 0 = A, 1 = B
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  // State and datapath registers; reset makes A win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      hold_cnt_q    <= 4'd0;
      sel_q         <= 1'b0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      hold_cnt_q    <= hold_cnt_d;
      sel_q         <= sel_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
    end
  end

  // Next grant, burst counting and bookkeeping on grant entry.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    hold_cnt_d    = hold_cnt_q;
    sel_d         = sel_q;

    case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          state_d = last_served_q ? GRANT_A : GRANT_B;
        end else if (bus.req_a) begin
          state_d = GRANT_A;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (bus.req_a) begin
          if (hold_cnt_q == HOLD_LAST) begin
            if (bus.req_b) begin
              state_d = GRANT_B;
            end else begin
              hold_cnt_d = 4'd0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end else begin
          state_d = bus.req_b ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (bus.req_b) begin
          if (hold_cnt_q == HOLD_LAST) begin
            if (bus.req_a) begin
              state_d = GRANT_A;
            end else begin
              hold_cnt_d = 4'd0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end else begin
          state_d = bus.req_a ? GRANT_A : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh grant restarts the burst and steers the select line; sel is
    // left untouched when falling back to IDLE.
    if (state_d == GRANT_A && state_q != GRANT_A) begin
      sel_d         = 1'b0;
      last_served_d = 1'b0;
      hold_cnt_d    = 4'd0;
    end else if (state_d == GRANT_B && state_q != GRANT_B) begin
      sel_d         = 1'b1;
      last_served_d = 1'b1;
      hold_cnt_d    = 4'd0;
    end
  end

  // Grant decode and capture of the granted nibble on transfer cycles.
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (state_q == GRANT_A && bus.req_a) begin
      data_out_d  = bus.data_a;
      valid_out_d = 1'b1;
    end else if (state_q == GRANT_B && bus.req_b) begin
      data_out_d  = bus.data_b;
      valid_out_d = 1'b1;
    end

    bus.gnt_a     = (state_q == GRANT_A);
    bus.gnt_b     = (state_q == GRANT_B);
    bus.sel       = sel_q;
    bus.data_out  = data_out_q;
    bus.valid_out = valid_out_q;
  end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Two-requester arbiter that shares a registered 4-bit selector datapath between producer A and producer B.
- Each producer presents a data nibble with a request line and receives a grant. The arbiter drives the select line, captures the granted nibble into a registered output with a valid strobe, and enforces round-robin fairness with a bounded burst length.
- Sits between the two digit/value sources and the downstream consumer (display/register-write path).

Parameters:
- DATA_W, 4, width of each data input and of data_out.
- HOLD_CYCLES, 4, maximum consecutive transfers to one requester while the other is requesting; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_a  input  1  requester A wants the datapath
- data_a  input  DATA_W  requester A data
- req_b  input  1  requester B wants the datapath
- data_b  input  DATA_W  requester B data
- gnt_a  output  1  registered grant to A
- gnt_b  output  1  registered grant to B
- sel  output  1  registered select: 0 = A, 1 = B
- data_out  output  DATA_W  registered captured data
- valid_out  output  1  one-cycle strobe: data_out updated this cycle

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE
  - gnt_a = 0, gnt_b = 0, sel = 0
  - data_out = 0, valid_out = 0
  - hold_cnt = 0
  - last_served = B, so A wins the first tie.
- States: IDLE, GRANT_A, GRANT_B (one-hot or encoded).
- Grant outputs decode from state: gnt_a = (state == GRANT_A), gnt_b = (state == GRANT_B). Never both high. sel is updated on grant entry and holds its value through IDLE.
- IDLE transitions:
  - req_a & req_b: grant the side != last_served.
  - Only req_a: go to GRANT_A.
  - Only req_b: go to GRANT_B.
  - Neither: stay in IDLE.
  - The grant appears one cycle after the request is sampled.
- Entering GRANT_X: sel <= X, last_served <= X, hold_cnt <= 0.
- Transfer: any cycle with gnt_x = 1 and req_x = 1.
  - At that edge, data_out <= data_x and valid_out <= 1.
  - Latency: data sampled at edge N is visible on data_out and valid_out after edge N.
- valid_out is 0 in every cycle with no transfer. data_out holds its last value.
- GRANT_X, on each transfer: hold_cnt <= hold_cnt + 1.
  - If hold_cnt == HOLD_CYCLES-1 and the other side is requesting, switch directly to GRANT_other. The transfer still completes and there is no idle cycle between grants.
  - If hold_cnt == HOLD_CYCLES-1 and the other side is not requesting, hold_cnt <= 0 and stay in GRANT_X (unlimited burst when uncontested).
- GRANT_X with req_x = 0: no transfer. Next state is GRANT_other if the other side is requesting, else IDLE.
- Requester contract: a requester may drop req at any time. Data is captured only in transfer cycles.
- Simultaneous release and request: A drops while B raises in the same cycle -> GRANT_B next cycle.
- Reset mid-burst: all registers return to reset values at that edge. valid_out = 0 on the following cycle, regardless of req lines.
- hold_cnt width is 4 bits. No other arithmetic.

Test Plan:
1. Reset with req_a = req_b = 1 asserted throughout -> after reset release: gnt_a = 1 one cycle later, sel = 0; the first valid_out carries data_a.
2. Only req_b = 1, data_b = 4'h9 held for 3 transfers -> gnt_b = 1, sel = 1; valid_out high 3 consecutive cycles with data_out = 9; gnt_a stays 0.
3. Both requesting continuously, HOLD_CYCLES = 4, data_a = 3, data_b = C -> data_out sequence 3,3,3,3,C,C,C,C,3,...; valid_out stays high throughout with no gap; gnt_a and gnt_b are never high together.
4. A bursting alone past HOLD_CYCLES (8 transfers, req_b = 0) -> gnt_a is held continuously and 8 valid strobes occur. Then raise req_b mid-burst -> switch occurs within at most 4 further transfers.
5. In GRANT_A, drop req_a for one cycle with req_b = 0 -> valid_out = 0 that cycle and state goes to IDLE. Re-raise req_a -> grant returns one cycle later.
6. Assert reset during a B burst (data_b = 5) -> next cycle gnt_b = 0, sel = 0, data_out = 0, valid_out = 0. After release with both requesting -> A is granted (last_served reset to B).
